// File: rtl/ibex_cheri_tagged_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : ibex_cheri_tagged_mem_resp
// Purpose  : Tag-aware data memory responder for the Ibex CHERI data interface
//            (req/gnt/rvalid). Serves 32-bit word accesses from local SRAM and
//            keeps one capability tag per 8-byte granule. A granule tag is set
//            only by a complete lo/hi capability store pair; every other write
//            to the granule clears it. Loads return the granule tag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MemWords     SRAM depth in 32-bit words (even, >= 4); tag depth MemWords/2
//   RespLatency  cycles from gnt to rvalid (1..4)
// Ports
//   clk_i          in   clock
//   rst_ni         in   asynchronous active-low reset
//   stall_i        in   wait-state injection, blocks gnt
//   data_req_i     in   request valid
//   data_gnt_o     out  request accepted this cycle (combinational)
//   data_rvalid_o  out  response valid
//   data_err_o     out  response error, qualified by rvalid
//   data_addr_i    in   byte address, [1:0] ignored
//   data_we_i      in   1 = store
//   data_be_i      in   byte enables
//   data_wdata_i   in   store data
//   data_cap_i     in   access is one half of a capability transfer
//   data_wtag_i    in   tag of the stored capability
//   data_rdata_o   out  load data (0 on error / store response)
//   data_rtag_o    out  granule tag & data_cap_i (0 on error)
// ============================================================================
module ibex_cheri_tagged_mem_resp #(
  parameter int unsigned MemWords    = 1024,
  parameter int unsigned RespLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        data_cap_i,
  input  logic        data_wtag_i,
  output logic [31:0] data_rdata_o,
  output logic        data_rtag_o
);

  localparam int unsigned AW   = $clog2(MemWords);
  localparam int unsigned TAGS = MemWords / 2;
  // response entry: {valid, err, rtag, rdata}
  localparam int unsigned EW   = 35;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LO_PEND = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_pend_tag;
  logic [AW-2:0]     r_pend_g;
  logic [TAGS-1:0]   r_tag;
  logic [31:0]       r_mem [MemWords];

  logic              w_gnt;
  logic              w_oob;
  logic              w_err;
  logic              w_ok;
  logic              w_wr;
  logic              w_rd;
  logic              w_tag_rd;
  logic [31:0]       w_rdata;
  logic [AW-1:0]     w_widx;
  logic [AW-2:0]     w_gidx;
  logic              w_unused;

  // Grants are suppressed while reset is held so no access slips in.
  assign w_gnt    = data_req_i & ~stall_i & rst_ni;
  assign w_oob    = (data_addr_i[31:2] >= 30'(MemWords));
  assign w_err    = w_oob | (data_cap_i & (data_be_i != 4'hF));
  assign w_ok     = w_gnt & ~w_err;
  assign w_wr     = w_ok & data_we_i;
  assign w_rd     = w_ok & ~data_we_i;
  assign w_widx   = data_addr_i[AW+1:2];
  assign w_gidx   = data_addr_i[AW+1:3];
  // Sampled before this cycle's write lands (non-blocking update below).
  assign w_rdata  = r_mem[w_widx];
  assign w_tag_rd = r_tag[w_gidx];
  assign w_unused = ^data_addr_i[1:0];

  assign data_gnt_o = w_gnt;

  // SRAM data array, no reset.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          r_mem[w_widx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Capability-store FSM and tag array. Only a lo half followed directly by the
  // matching hi half of the same granule can leave a tag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_pend_tag <= 1'b0;
      r_pend_g   <= '0;
      r_tag      <= '0;
    end else if (w_gnt) begin
      if (w_err) begin
        r_state <= IDLE;
      end else if (data_we_i && data_cap_i && !data_addr_i[2]) begin
        r_tag[w_gidx] <= 1'b0;
        r_pend_tag    <= data_wtag_i;
        r_pend_g      <= w_gidx;
        r_state       <= LO_PEND;
      end else if (data_we_i && data_cap_i && (r_state == LO_PEND) &&
                   (w_gidx == r_pend_g)) begin
        r_tag[w_gidx] <= r_pend_tag & data_wtag_i;
        r_state       <= IDLE;
      end else if (data_we_i) begin
        r_tag[w_gidx] <= 1'b0;
        r_state       <= IDLE;
      end else begin
        // load: aborts a pending capability store
        r_state <= IDLE;
      end
    end
  end

  // Fixed-depth response pipeline; stage 0 is loaded in the grant cycle.
  logic [EW-1:0]                  w_entry;
  logic [RespLatency-1:0][EW-1:0] r_pipe;
  logic [RespLatency-1:0][EW-1:0] w_pipe_nxt;
  logic [EW-1:0]                  w_last;

  assign w_entry = {w_gnt, w_gnt & w_err, w_rd & w_tag_rd & data_cap_i,
                    w_rd ? w_rdata : 32'h0};

  generate
    if (RespLatency == 1) begin : g_lat_one
      assign w_pipe_nxt = w_entry;
    end else begin : g_lat_multi
      assign w_pipe_nxt = {r_pipe[RespLatency-2:0], w_entry};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= w_pipe_nxt;
    end
  end

  assign w_last        = r_pipe[RespLatency-1];
  assign data_rvalid_o = w_last[34];
  assign data_err_o    = w_last[33];
  assign data_rtag_o   = w_last[32];
  assign data_rdata_o  = w_last[31:0];

endmodule
`default_nettype wire

// File: tb/tb_ibex_cheri_tagged_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_cheri_tagged_mem_resp
// Purpose  : Scoreboard bench. DUT A (RespLatency=3) carries the functional
//            tests; DUT B (RespLatency=2) shares the stimulus and is reset
//            mid-operation to show in-flight responses and tags are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_cheri_tagged_mem_resp;

  localparam int LAT_A = 3;
  localparam int LAT_B = 2;
  localparam int MW    = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b, stall, req, we, cap, wtag;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        a_gnt, a_rvalid, a_err, a_rtag;
  logic        b_gnt, b_rvalid, b_err, b_rtag;
  logic [31:0] a_rdata, b_rdata;

  ibex_cheri_tagged_mem_resp #(.MemWords(MW), .RespLatency(LAT_A)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n_a), .stall_i(stall), .data_req_i(req),
    .data_gnt_o(a_gnt), .data_rvalid_o(a_rvalid), .data_err_o(a_err),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_cap_i(cap), .data_wtag_i(wtag), .data_rdata_o(a_rdata), .data_rtag_o(a_rtag)
  );

  ibex_cheri_tagged_mem_resp #(.MemWords(MW), .RespLatency(LAT_B)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n_b), .stall_i(stall), .data_req_i(req),
    .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid), .data_err_o(b_err),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_cap_i(cap), .data_wtag_i(wtag), .data_rdata_o(b_rdata), .data_rtag_o(b_rtag)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
    logic        rtag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   b_watch = 1'b0;
  bit   b_track = 1'b0;

  // reference model of memory, tags and the lo/hi pairing
  logic [31:0] m_mem [MW];
  logic        m_tag [MW/2];
  logic        m_lo, m_pt;
  int          m_pg;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // model: evaluate every grant at the edge that accepts it
  always @(posedge clk) begin
    if (rst_n_a && req && !stall) begin
      exp_t e;
      int   w, g;
      logic er;
      w  = int'(addr[31:2]);
      g  = int'(addr[31:3]);
      er = (addr[31:2] >= 30'(MW)) || (cap && be != 4'hF);
      e.due = cyc + LAT_A; e.err = er; e.rdata = 32'h0; e.rtag = 1'b0;
      if (!er && !we) begin
        e.rdata = m_mem[w];
        e.rtag  = m_tag[g] & cap;
      end
      qa.push_back(e);
      if (b_track && rst_n_b) begin
        exp_t eb;
        eb = e; eb.due = cyc + LAT_B; eb.rtag = 1'b0;
        qb.push_back(eb);
      end
      if (er) begin
        m_lo = 1'b0;
      end else if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_mem[w][8*b +: 8] = wdata[8*b +: 8];
        if (cap && !addr[2]) begin
          m_tag[g] = 1'b0; m_pt = wtag; m_pg = g; m_lo = 1'b1;
        end else if (cap && addr[2] && m_lo && g == m_pg) begin
          m_tag[g] = m_pt & wtag; m_lo = 1'b0;
        end else begin
          m_tag[g] = 1'b0; m_lo = 1'b0;
        end
      end else begin
        m_lo = 1'b0;
      end
    end
    cyc++;
  end

  // monitors sample on the falling edge
  always @(negedge clk) begin
    if (rst_n_a) begin
      if (req) chk("a_gnt", a_gnt, !stall);
      if (a_rvalid) begin
        if (qa.size() == 0) chk("a_spurious_rvalid", 1, 0);
        else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_latency", cyc, e.due);
          chk("a_err", a_err, e.err);
          chk("a_rdata", a_rdata, e.rdata);
          chk("a_rtag", a_rtag, e.rtag);
        end
      end else if (qa.size() > 0 && qa[0].due < cyc) begin
        void'(qa.pop_front());
        chk("a_rvalid_timeout", 0, 1);
      end
    end
    if (b_watch) chk("b_rvalid_after_rst", b_rvalid, 0);
    if (b_track) begin
      if (b_rvalid) begin
        if (qb.size() == 0) chk("b_spurious_rvalid", 1, 0);
        else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_latency", cyc, e.due);
          chk("b_err", b_err, e.err);
          chk("b_rdata", b_rdata, e.rdata);
          chk("b_rtag", b_rtag, e.rtag);
        end
      end else if (qb.size() > 0 && qb[0].due < cyc) begin
        void'(qb.pop_front());
        chk("b_rvalid_timeout", 0, 1);
      end
    end
  end

  // hold one access until granted; stall for nst cycles first
  task automatic issue(input bit iwe, input bit icap, input logic [31:0] iaddr,
                       input logic [3:0] ibe, input logic [31:0] iwd, input bit iwt,
                       input int nst);
    we = iwe; cap = icap; addr = iaddr; be = ibe; wdata = iwd; wtag = iwt;
    req = 1'b1;
    stall = (nst > 0);
    for (int i = 0; i < nst; i++) begin @(posedge clk); #1; end
    stall = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cst(input logic [31:0] a, input logic [31:0] d, input bit t);
    issue(1'b1, 1'b1, a, 4'hF, d, t, 0);
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    issue(1'b1, 1'b0, a, b, d, 1'b0, 0);
  endtask

  task automatic ld(input logic [31:0] a, input bit c);
    issue(1'b0, c, a, 4'hF, 32'h0, 1'b0, 0);
  endtask

  task automatic idle_n(input int n);
    req = 1'b0; stall = 1'b0;
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    req = 1'b0; stall = 1'b0;
    for (int i = 0; i < 30 && (qa.size() > 0 || qb.size() > 0); i++) begin
      @(posedge clk); #1;
    end
    idle_n(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MW/2; i++) m_tag[i] = 1'b0;
    for (int i = 0; i < MW; i++) m_mem[i] = 32'h0;
    m_lo = 1'b0; m_pt = 1'b0; m_pg = 0;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    req = 1'b0; stall = 1'b0; we = 1'b0; cap = 1'b0; wtag = 1'b0;
    addr = 32'h0; wdata = 32'h0; be = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    req = 1'b1;
    #1;
    chk("rst_gnt", a_gnt, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_rtag", a_rtag, 0);
    req = 1'b0;
    @(posedge clk); #1;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(posedge clk); #1;

    // complete capability store pair sets the tag
    cst(32'h100, 32'h1111_2222, 1'b1);
    cst(32'h104, 32'h3333_4444, 1'b1);
    ld(32'h100, 1'b1);
    ld(32'h104, 1'b1);
    drain();

    // byte store into the granule clears the tag
    st(32'h104, 4'h2, 32'h0000_AB00);
    ld(32'h100, 1'b1);
    ld(32'h104, 1'b0);
    drain();

    // interrupted pair leaves the tag clear
    st(32'h200, 4'hF, 32'hCAFE_F00D);
    cst(32'h100, 32'h5555_6666, 1'b1);
    ld(32'h200, 1'b0);
    cst(32'h104, 32'h7777_8888, 1'b1);
    ld(32'h100, 1'b1);
    drain();

    // tagged granule: non-cap load sees rtag=0, cap load sees 1
    cst(32'h108, 32'hA0A0_0001, 1'b1);
    cst(32'h10C, 32'hA0A0_0002, 1'b1);
    ld(32'h108, 1'b0);
    ld(32'h10C, 1'b1);
    // hi half with wtag=0 yields a clear tag
    cst(32'h118, 32'hB0B0_0001, 1'b1);
    cst(32'h11C, 32'hB0B0_0002, 1'b0);
    ld(32'h118, 1'b1);
    // hi half with no pending lo leaves the tag clear
    cst(32'h124, 32'hC0C0_0002, 1'b1);
    ld(32'h120, 1'b1);
    drain();

    // errors: out-of-range store must not alias, partial cap store rejected
    st(32'h0, 4'hF, 32'h5A5A_5A5A);
    st(32'h0000_0400, 4'hF, 32'hDEAD_BEEF);
    ld(32'h0, 1'b0);
    st(32'h110, 4'hF, 32'h0102_0304);
    issue(1'b1, 1'b1, 32'h110, 4'h3, 32'hFFFF_FFFF, 1'b1, 0);
    ld(32'h110, 1'b0);
    ld(32'h0000_0400, 1'b1);
    drain();

    // grants with stall toggling: latency and ordering
    issue(1'b0, 1'b0, 32'h200, 4'hF, 32'h0, 1'b0, 1);
    issue(1'b1, 1'b0, 32'h204, 4'hF, 32'h1234_5678, 1'b0, 0);
    issue(1'b0, 1'b0, 32'h204, 4'hF, 32'h0, 1'b0, 2);
    issue(1'b0, 1'b1, 32'h10C, 4'hF, 32'h0, 1'b0, 1);
    drain();

    // reset of DUT B one cycle after two grants: responses dropped, tags cleared
    ld(32'h108, 1'b1);
    ld(32'h10C, 1'b1);
    req = 1'b0;
    rst_n_b = 1'b0;
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    b_watch = 1'b1;
    idle_n(8);
    b_watch = 1'b0;
    drain();
    b_track = 1'b1;
    ld(32'h108, 1'b1);
    ld(32'h10C, 1'b1);
    ld(32'h100, 1'b1);
    drain();
    b_track = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
